// File: rtl/agc_bench_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | agc_bench_pkg: shared WL-width, feeder state and FIFO entry types     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package agc_bench_pkg;

  localparam int WL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLD    = 2'd2
  } wl_state_e;

  typedef struct packed {
    logic            ext;
    logic [WL_W-1:0] word;
  } wl_entry_t;

endpackage
`default_nettype wire

// File: rtl/agc_wl_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | agc_wl_fifo: instruction-word FIFO, DEPTH entries of DW bits         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module agc_wl_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 17
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/agc_wl_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | agc_wl_feeder: presents one queued instruction word per MCT on WL     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module agc_wl_feeder
  import agc_bench_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = WL_W
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         t01,
  input  logic         t10,
  input  logic         t12,
  input  logic         gojam,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [W-1:0] ld_word,
  input  logic         ld_ext,
  output logic [W-1:0] wl,
  output logic [W-1:0] wl_n,
  output logic         nisq,
  output logic         ext,
  output logic         empty,
  output logic [7:0]   underrun
);

  localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

  logic      t01_q, t10_q, t12_q;
  logic      t01_rise, t10_rise, t12_rise;
  wl_state_e state, state_nx;
  logic [W-1:0] wl_nx;
  logic      nisq_nx, ext_nx;
  logic      pop, starve, full;
  logic [W:0] head;

  agc_wl_fifo #(
    .DEPTH (DEPTH),
    .DW    (W + 1)
  ) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (ld_valid),
    .push_data ({ld_ext, ld_word}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign ld_ready = !full;
  assign wl_n     = ~wl;

  assign t01_rise = t01 && !t01_q;
  assign t10_rise = t10 && !t10_q;
  assign t12_rise = t12 && !t12_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      t01_q    <= 1'b0;
      t10_q    <= 1'b0;
      t12_q    <= 1'b0;
      state    <= ST_IDLE;
      wl       <= '0;
      nisq     <= 1'b0;
      ext      <= 1'b0;
      underrun <= '0;
    end else begin
      t01_q <= t01;
      t10_q <= t10;
      t12_q <= t12;
      state <= state_nx;
      wl    <= wl_nx;
      nisq  <= nisq_nx;
      ext   <= ext_nx;
      if (starve && underrun != UNDERRUN_MAX) underrun <= underrun + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    wl_nx    = wl;
    nisq_nx  = nisq;
    ext_nx   = ext;
    pop      = 1'b0;
    starve   = 1'b0;
    if (gojam) begin
      state_nx = ST_IDLE;
      wl_nx    = '0;
      nisq_nx  = 1'b0;
      ext_nx   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (t10_rise) begin
            if (!empty) begin
              pop      = 1'b1;
              wl_nx    = head[W-1:0];
              ext_nx   = head[W];
              nisq_nx  = 1'b1;
              state_nx = ST_PRESENT;
            end else begin
              starve = 1'b1;
            end
          end
        end
        // A stray t10 here means a timer fault; the word stays on WL.
        ST_PRESENT: if (t12_rise) state_nx = ST_HOLD;
        ST_HOLD: begin
          if (t01_rise) begin
            state_nx = ST_IDLE;
            wl_nx    = '0;
            nisq_nx  = 1'b0;
            ext_nx   = 1'b0;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_agc_wl_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_agc_wl_feeder: randomized self-checking bench with queue model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_agc_wl_feeder;
  import agc_bench_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = WL_W;

  logic         clock = 1'b0;
  logic         rst_n = 1'b1;
  logic         t01 = 1'b0, t10 = 1'b0, t12 = 1'b0, gojam = 1'b0;
  logic         ld_valid = 1'b0, ld_ext = 1'b0;
  logic [W-1:0] ld_word = '0;
  logic         ld_ready, nisq, ext, empty;
  logic [W-1:0] wl, wl_n;
  logic [7:0]   underrun;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of pending words plus what WL should show now.
  wl_entry_t    q[$];
  wl_entry_t    seen[$];
  logic [W-1:0] m_wl;
  logic         m_nisq, m_ext, m_busy, m_seen12;
  logic         m_p01, m_p10, m_p12;
  logic [7:0]   m_under;
  int           phase = 0;
  int           cur_phase = 0;
  logic         last_nisq = 1'b0;

  always #5 clock = ~clock;

  agc_wl_feeder #(.DEPTH(DEPTH), .W(W)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .t01      (t01),
    .t10      (t10),
    .t12      (t12),
    .gojam    (gojam),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_word  (ld_word),
    .ld_ext   (ld_ext),
    .wl       (wl),
    .wl_n     (wl_n),
    .nisq     (nisq),
    .ext      (ext),
    .empty    (empty),
    .underrun (underrun)
  );

  task automatic model_reset();
    q.delete();
    m_wl = '0; m_nisq = 1'b0; m_ext = 1'b0; m_busy = 1'b0; m_seen12 = 1'b0;
    m_p01 = 1'b0; m_p10 = 1'b0; m_p12 = 1'b0; m_under = '0;
  endtask

  // One clock: timer drives 12 timepulses of 2 clocks each, 24 clocks per MCT.
  task automatic step();
    logic r01, r10, r12, can;
    wl_entry_t e;
    cur_phase = phase;
    t01 = (phase / 2 == 0);
    t10 = (phase / 2 == 9);
    t12 = (phase / 2 == 11);
    if (!rst_n) begin
      model_reset();
    end else begin
      r01 = t01 && !m_p01;
      r10 = t10 && !m_p10;
      r12 = t12 && !m_p12;
      can = ld_valid && (q.size() < DEPTH);
      if (gojam) begin
        m_busy = 1'b0; m_seen12 = 1'b0; m_wl = '0; m_nisq = 1'b0; m_ext = 1'b0;
      end else if (!m_busy) begin
        if (r10) begin
          if (q.size() > 0) begin
            e = q.pop_front();
            m_wl = e.word; m_ext = e.ext; m_nisq = 1'b1; m_busy = 1'b1; m_seen12 = 1'b0;
          end else if (m_under != 8'd255) begin
            m_under = m_under + 8'd1;
          end
        end
      end else if (!m_seen12) begin
        if (r12) m_seen12 = 1'b1;
      end else if (r01) begin
        m_busy = 1'b0; m_wl = '0; m_nisq = 1'b0; m_ext = 1'b0;
      end
      if (can) begin
        e.ext = ld_ext; e.word = ld_word;
        q.push_back(e);
      end
      m_p01 = t01; m_p10 = t10; m_p12 = t12;
    end
    @(posedge clock); #1;
    phase = (phase + 1) % 24;
    if (nisq === 1'b1 && last_nisq !== 1'b1) begin
      e.ext = ext; e.word = wl;
      seen.push_back(e);
    end
    last_nisq = nisq;
  endtask

  task automatic align();
    while (phase != 0) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    ld_valid = 1'b1; ld_word = 16'o12345; ld_ext = 1'b1;
    step();
    ld_valid = 1'b0;
    for (int k = 0; k < 40 && nisq !== 1'b1; k++) begin
      step();
      total++;
      if ({wl, wl_n, nisq, ext, empty, ld_ready, underrun} !==
          {m_wl, ~m_wl, m_nisq, m_ext, q.size() == 0, q.size() < DEPTH, m_under}) begin
        bad++;
        $display("FAIL reset_prelude wl=%h nisq=%b ext=%b und=%0d want wl=%h nisq=%b ext=%b und=%0d",
                 wl, nisq, ext, underrun, m_wl, m_nisq, m_ext, m_under);
      end
    end
    total++;
    if (nisq !== 1'b1) begin bad++; $display("FAIL reset_prelude_present nisq=%b want 1", nisq); end
    step(); step();
    rst_n = 1'b0;
    #1;
    total++; if (wl !== 16'h0000)   begin bad++; $display("FAIL reset_wl got %h want 0000", wl); end
    total++; if (wl_n !== 16'hFFFF) begin bad++; $display("FAIL reset_wl_n got %h want ffff", wl_n); end
    total++; if (nisq !== 1'b0)     begin bad++; $display("FAIL reset_nisq got %b want 0", nisq); end
    total++; if (ext !== 1'b0)      begin bad++; $display("FAIL reset_ext got %b want 0", ext); end
    total++; if (underrun !== 8'd0) begin bad++; $display("FAIL reset_underrun got %0d want 0", underrun); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
    total++; if (empty !== 1'b1)    begin bad++; $display("FAIL reset_empty got %b want 1", empty); end
    model_reset();
    step();
    align();
    rst_n = 1'b1;
    repeat (24) begin
      step();
      total++;
      if ({wl, nisq, ext, underrun} !== {m_wl, m_nisq, m_ext, m_under}) begin
        bad++;
        $display("FAIL reset_after wl=%h nisq=%b und=%0d want wl=%h nisq=%b und=%0d",
                 wl, nisq, underrun, m_wl, m_nisq, m_under);
      end
    end
  endtask

  task automatic test_single();
    logic         en;
    logic [W-1:0] ew;
    align();
    ld_valid = 1'b1; ld_word = 16'o10000; ld_ext = 1'b0;
    step();
    ld_valid = 1'b0;
    for (int i = 0; i < 31; i++) begin
      step();
      en = (i >= 17 && i <= 22);
      ew = en ? 16'o10000 : 16'h0000;
      total++;
      if (nisq !== en || wl !== ew || wl_n !== ~ew || ext !== 1'b0) begin
        bad++;
        $display("FAIL single_word cyc=%0d nisq=%b wl=%o ext=%b want nisq=%b wl=%o ext=0",
                 i, nisq, wl, ext, en, ew);
      end
    end
  endtask

  task automatic test_extend();
    align();
    seen.delete();
    ld_valid = 1'b1; ld_word = 16'o00006; ld_ext = 1'b1;
    step();
    ld_word = 16'o20000; ld_ext = 1'b0;
    step();
    ld_valid = 1'b0;
    repeat (60) begin
      step();
      total++;
      if ({wl, wl_n, nisq, ext, empty, ld_ready} !==
          {m_wl, ~m_wl, m_nisq, m_ext, q.size() == 0, q.size() < DEPTH}) begin
        bad++;
        $display("FAIL extend_cycle wl=%o nisq=%b ext=%b want wl=%o nisq=%b ext=%b",
                 wl, nisq, ext, m_wl, m_nisq, m_ext);
      end
    end
    total++;
    if (seen.size() != 2) begin
      bad++; $display("FAIL extend_count got %0d want 2", seen.size());
    end else begin
      total++;
      if (seen[0] !== {1'b1, 16'o00006}) begin
        bad++; $display("FAIL extend_first got ext=%b wl=%o want ext=1 wl=00006", seen[0].ext, seen[0].word);
      end
      total++;
      if (seen[1] !== {1'b0, 16'o20000}) begin
        bad++; $display("FAIL extend_second got ext=%b wl=%o want ext=0 wl=20000", seen[1].ext, seen[1].word);
      end
    end
  endtask

  task automatic test_full();
    wl_entry_t exp[9];
    int        acc_phase;
    logic      rdy;
    for (int k = 0; k < 9; k++) begin
      exp[k].word = W'($urandom);
      exp[k].ext  = 1'($urandom);
    end
    align();
    seen.delete();
    for (int k = 0; k < 8; k++) begin
      ld_valid = 1'b1; ld_word = exp[k].word; ld_ext = exp[k].ext;
      step();
    end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %b want 0", ld_ready); end
    total++; if (empty !== 1'b0)    begin bad++; $display("FAIL full_empty got %b want 0", empty); end
    ld_word = exp[8].word; ld_ext = exp[8].ext;
    acc_phase = -1;
    for (int k = 0; k < 40 && acc_phase < 0; k++) begin
      rdy = ld_ready;
      step();
      if (rdy === 1'b1) acc_phase = cur_phase;
    end
    ld_valid = 1'b0;
    total++;
    if (acc_phase != 19) begin
      bad++; $display("FAIL full_accept_phase got %0d want 19", acc_phase);
    end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL full_refill_ready got %b want 0", ld_ready); end
    repeat (240) begin
      step();
      total++;
      if ({wl, wl_n, nisq, ext, empty, ld_ready} !==
          {m_wl, ~m_wl, m_nisq, m_ext, q.size() == 0, q.size() < DEPTH}) begin
        bad++;
        $display("FAIL full_cycle wl=%h nisq=%b empty=%b rdy=%b want wl=%h nisq=%b empty=%b rdy=%b",
                 wl, nisq, empty, ld_ready, m_wl, m_nisq, q.size() == 0, q.size() < DEPTH);
      end
    end
    total++;
    if (seen.size() != 9) begin
      bad++; $display("FAIL full_count got %0d want 9", seen.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        total++;
        if (seen[k] !== exp[k]) begin
          bad++; $display("FAIL full_order idx=%0d got %h want %h", k, seen[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    int highs;
    rst_n = 1'b0;
    #1;
    model_reset();
    step();
    align();
    rst_n = 1'b1;
    highs = 0;
    repeat (72) begin
      step();
      if (nisq !== 1'b0) highs++;
    end
    total++; if (underrun !== 8'd3) begin bad++; $display("FAIL underrun_3 got %0d want 3", underrun); end
    total++; if (highs != 0)        begin bad++; $display("FAIL underrun_nisq got %0d high cycles want 0", highs); end
    repeat (257 * 24) begin
      step();
      total++;
      if ({underrun, nisq} !== {m_under, m_nisq}) begin
        bad++; $display("FAIL underrun_cycle und=%0d nisq=%b want und=%0d nisq=%b", underrun, nisq, m_under, m_nisq);
      end
    end
    total++; if (underrun !== 8'd255) begin bad++; $display("FAIL underrun_sat got %0d want 255", underrun); end
  endtask

  task automatic test_gojam();
    wl_entry_t exp[3];
    for (int k = 0; k < 3; k++) begin
      exp[k].word = W'($urandom);
      exp[k].ext  = 1'($urandom);
    end
    align();
    seen.delete();
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1; ld_word = exp[k].word; ld_ext = exp[k].ext;
      step();
    end
    ld_valid = 1'b0;
    for (int k = 0; k < 40 && seen.size() == 0; k++) step();
    step(); step();
    gojam = 1'b1;
    step();
    total++; if (nisq !== 1'b0)   begin bad++; $display("FAIL gojam_nisq got %b want 0", nisq); end
    total++; if (wl !== 16'h0000) begin bad++; $display("FAIL gojam_wl got %h want 0000", wl); end
    repeat (30) step();
    gojam = 1'b0;
    total++; if (seen.size() != 1) begin bad++; $display("FAIL gojam_hold got %0d words want 1", seen.size()); end
    total++; if (empty !== 1'b0)   begin bad++; $display("FAIL gojam_kept empty=%b want 0", empty); end
    for (int k = 0; k < 40 && seen.size() < 2; k++) step();
    total++;
    if (seen.size() != 2 || cur_phase != 18) begin
      bad++; $display("FAIL gojam_resume words=%0d phase=%0d want 2 at 18", seen.size(), cur_phase);
    end
    repeat (48) step();
    total++;
    if (seen.size() != 3) begin
      bad++; $display("FAIL gojam_count got %0d want 3", seen.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (seen[k] !== exp[k]) begin
          bad++; $display("FAIL gojam_order idx=%0d got %h want %h", k, seen[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (20 * 24) begin
      ld_valid = ($urandom_range(2) == 0);
      ld_word  = W'($urandom);
      ld_ext   = 1'($urandom);
      gojam    = ($urandom_range(40) == 0);
      step();
      total++;
      if ({wl, wl_n, nisq, ext, empty, ld_ready, underrun} !==
          {m_wl, ~m_wl, m_nisq, m_ext, q.size() == 0, q.size() < DEPTH, m_under}) begin
        bad++;
        $display("FAIL random_cycle wl=%h nisq=%b ext=%b empty=%b rdy=%b und=%0d want wl=%h nisq=%b ext=%b empty=%b rdy=%b und=%0d",
                 wl, nisq, ext, empty, ld_ready, underrun,
                 m_wl, m_nisq, m_ext, q.size() == 0, q.size() < DEPTH, m_under);
      end
    end
    ld_valid = 1'b0;
    gojam    = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_single();
    test_extend();
    test_full();
    test_underrun();
    test_gojam();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
